// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - 16-bit ADD/SUB/INC/DEC sequenced as two byte passes through an 8-bit ALU

package gate_boy_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int FLAG_WIDTH = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } instruction_t;
endpackage

module alu16_sequencer
  import gate_boy_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [15:0]           req_a,
  input  logic [15:0]           req_b,
  output logic [DATA_WIDTH-1:0] alu_operand_A,
  output logic [DATA_WIDTH-1:0] alu_operand_B,
  output instruction_t          alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_result,
  output logic [FLAG_WIDTH-1:0] rsp_flags,
  output logic                  rsp_flags_we
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  localparam logic [3:0] PASS_CYCLES = 4'(ALU_LATENCY);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [1:0]              op_q, op_d;
  logic [15:0]             a_q, a_d;
  logic [15:0]             b_q, b_d;
  logic [7:0]              lo_q, lo_d;
  logic [15:0]             rsp_result_q, rsp_result_d;
  logic [FLAG_WIDTH-1:0]   rsp_flags_q, rsp_flags_d;
  logic                    rsp_we_q, rsp_we_d;

  // op[0] selects the subtracting forms, op[1] selects the increment/decrement forms
  logic is_sub, is_incdec;
  assign is_sub    = op_q[0];
  assign is_incdec = op_q[1];

  // Z and N are produced here; only H and C come from the ALU
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flags[3:2];

  logic [15:0] full_result;
  assign full_result = {alu_result, lo_q};

  // State and datapath registers; reset aborts any pass in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      op_q         <= 2'd0;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      lo_q         <= 8'h00;
      rsp_result_q <= 16'h0000;
      rsp_flags_q  <= '0;
      rsp_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      lo_q         <= lo_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_we_q     <= rsp_we_d;
    end
  end

  // Next-state, pass timing and ALU drive; ALU outputs are a pure function of state and captured operands
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    lo_d          = lo_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_we_d      = rsp_we_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    alu_operand_A = 8'h00;
    alu_operand_B = 8'h00;
    alu_opcode    = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          cnt_d   = PASS_CYCLES;
          state_d = S_LO;
        end
      end
      S_LO: begin
        alu_operand_A = a_q[7:0];
        alu_operand_B = is_incdec ? 8'h01 : b_q[7:0];
        alu_opcode    = is_sub ? ALU_SUB : ALU_ADD;
        if (cnt_q == 4'd1) begin
          lo_d    = alu_result;
          cnt_d   = PASS_CYCLES;
          state_d = S_HI;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HI: begin
        alu_operand_A = a_q[15:8];
        alu_operand_B = is_incdec ? 8'h00 : b_q[15:8];
        alu_opcode    = is_sub ? ALU_SBC : ALU_ADC;
        if (cnt_q == 4'd1) begin
          rsp_result_d = full_result;
          if (is_incdec) begin
            rsp_flags_d = '0;
            rsp_we_d    = 1'b0;
          end else begin
            rsp_flags_d = {full_result == 16'h0000, is_sub, alu_flags[1], alu_flags[0]};
            rsp_we_d    = 1'b1;
          end
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_result   = rsp_result_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_flags_we = rsp_we_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb/tb_alu16_sequencer.sv - scoreboard bench for alu16_sequencer with a behavioural 8-bit ALU

module tb_alu16_sequencer;
  import gate_boy_pkg::*;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'd0;
  logic [15:0]  req_a = 16'h0;
  logic [15:0]  req_b = 16'h0;
  logic [7:0]   alu_operand_A, alu_operand_B;
  instruction_t alu_opcode;
  logic [7:0]   alu_result;
  logic [3:0]   alu_flags;
  logic         rsp_valid;
  logic [15:0]  rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_flags_we;

  alu16_sequencer #(.ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_flags_we(rsp_flags_we)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural 8-bit ALU with its own carry flag, latched whenever a plain ADD/SUB is presented
  logic c_reg = 1'b0;
  always_comb begin
    int ia, ib, ic, r;
    logic h, c, n;
    ia = int'(alu_operand_A);
    ib = int'(alu_operand_B);
    ic = int'(c_reg);
    r = 0; h = 1'b0; c = 1'b0; n = 1'b0;
    case (alu_opcode)
      ALU_ADD: begin r = ia + ib;      h = ((ia % 16) + (ib % 16)) > 15;      c = r > 255; end
      ALU_ADC: begin r = ia + ib + ic; h = ((ia % 16) + (ib % 16) + ic) > 15; c = r > 255; end
      ALU_SUB: begin r = ia - ib;      h = (ia % 16) < (ib % 16);        c = ia < ib;        n = 1'b1; end
      ALU_SBC: begin r = ia - ib - ic; h = (ia % 16) < ((ib % 16) + ic); c = ia < (ib + ic); n = 1'b1; end
      default: r = 0;
    endcase
    alu_result = 8'(r);
    alu_flags  = {8'(r) == 8'h00, n, h, c};
  end
  always @(posedge clk) if (alu_opcode == ALU_ADD || alu_opcode == ALU_SUB) c_reg <= alu_flags[0];

  // 16-bit reference model: result and flags from whole-word arithmetic
  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, res;
    logic [3:0]  flags;
    logic        we;
    int          acc;
  } exp_t;

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t e;
    int ua, ub;
    logic h, c;
    ua = int'(a); ub = int'(b);
    e.op = op; e.a = a; e.b = b; e.acc = acc;
    case (op)
      2'd0: begin e.res = 16'(ua + ub); h = ((ua % 4096) + (ub % 4096)) > 4095; c = (ua + ub) > 65535;
                  e.flags = {e.res == 16'h0, 1'b0, h, c}; e.we = 1'b1; end
      2'd1: begin e.res = 16'(ua - ub); h = (ua % 4096) < (ub % 4096); c = ua < ub;
                  e.flags = {e.res == 16'h0, 1'b1, h, c}; e.we = 1'b1; end
      2'd2: begin e.res = 16'(ua + 1); e.flags = 4'h0; e.we = 1'b0; end
      default: begin e.res = 16'(ua - 1); e.flags = 4'h0; e.we = 1'b0; end
    endcase
    return e;
  endfunction

  exp_t exp_q[$];
  logic held_mode = 1'b0;
  int   last_rsp = -1;

  // Monitor: ALU drive per pass, ready, responses against the scoreboard, and accept capture
  always @(negedge clk) begin : mon
    int k;
    exp_t e;
    logic [7:0] ea, eb;
    instruction_t eop;
    if (rst) begin
      exp_q.delete();
    end else begin
      k = cyc;
      ea = 8'h00; eb = 8'h00; eop = ALU_ADD;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (k >= e.acc && k < e.acc + L) begin
          ea = e.a[7:0]; eb = e.op[1] ? 8'h01 : e.b[7:0]; eop = e.op[0] ? ALU_SUB : ALU_ADD;
        end else if (k >= e.acc + L && k < e.acc + 2 * L) begin
          ea = e.a[15:8]; eb = e.op[1] ? 8'h00 : e.b[15:8]; eop = e.op[0] ? ALU_SBC : ALU_ADC;
        end
      end
      chk("alu_operand_A", 32'(alu_operand_A), 32'(ea));
      chk("alu_operand_B", 32'(alu_operand_B), 32'(eb));
      chk("alu_opcode", 32'(alu_opcode), 32'(eop));
      chk("req_ready", 32'(req_ready), 32'(exp_q.size() == 0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
          chk("rsp_flags_we", 32'(rsp_flags_we), 32'(e.we));
          chk("rsp_latency", 32'(k - e.acc), 32'(2 * L));
          if (held_mode && last_rsp >= 0) chk("rsp_spacing", 32'(k - last_rsp), 32'(2 * L + 2));
          last_rsp = k;
        end
      end else if (exp_q.size() > 0 && k > exp_q[0].acc + 2 * L) begin
        chk("missing_rsp", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      if (req_valid && req_ready) exp_q.push_back(model(req_op, req_a, req_b, k + 1));
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bit ok;
    @(posedge clk); #1;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_rsp_flags_we"}, 32'(rsp_flags_we), 32'd0);
    chk({tag, "_alu_A"}, 32'(alu_operand_A), 32'd0);
    chk({tag, "_alu_B"}, 32'(alu_operand_B), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_opcode), 32'(ALU_ADD));
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #3 rst = 1'b0;

    // Directed vectors
    send(2'd0, 16'h0FFF, 16'h0001); drain();
    send(2'd0, 16'hFFFF, 16'h0001); drain();
    send(2'd1, 16'h1000, 16'h0001); drain();
    send(2'd2, 16'hFFFF, 16'h1234); drain();
    send(2'd3, 16'h0000, 16'hABCD); drain();
    send(2'd1, 16'h0005, 16'h0005); drain();

    // Reset during the HI pass aborts the operation without a response
    send(2'd0, 16'h1234, 16'h4321);
    repeat (L + 1) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("midop");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (2 * L + 4) @(posedge clk);
    send(2'd0, 16'h0001, 16'h0001); drain();

    // Request held high while operands change every cycle
    held_mode = 1'b1;
    last_rsp = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      req_op = 2'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();
    held_mode = 1'b0;

    // Random operations with random gaps
    for (int i = 0; i < 30; i++) begin
      send(2'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu16_sequencer.md
ALU16_SEQUENCER -- requirements
Module: alu16_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter ALU_LATENCY, default 4, SHALL be the clk cycles the 8-bit ALU needs per operation (one M-cycle); legal range 1-15.
REQ-003 Width constants DATA_WIDTH (8) and FLAG_WIDTH (4), and type instruction_t, SHALL come from gate_boy_pkg.
REQ-004 clk  in  1  system clock, 4 MHz T-cycle.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  16-bit operation request.
REQ-007 req_ready  out  1  sequencer idle; request accepted on clk edge when req_valid&&req_ready.
REQ-008 req_op  in  2  00 ADD16, 01 SUB16, 10 INC16, 11 DEC16.
REQ-009 req_a, req_b  in  16 each  operands; req_b ignored for INC16/DEC16.
REQ-010 alu_operand_A, alu_operand_B  out  DATA_WIDTH each  byte operands to ALU.
REQ-011 alu_opcode  out  instruction_t  ALU opcode.
REQ-012 alu_result  in  DATA_WIDTH; alu_flags  in  FLAG_WIDTH, [3]=Z [2]=N [1]=H [0]=C.
REQ-013 rsp_valid  out  1  one-cycle response strobe.
REQ-014 rsp_result  out  16; rsp_flags  out  FLAG_WIDTH; rsp_flags_we  out  1  flags to be written back.

Function
REQ-015 FSM states IDLE, LO, HI, RESP; IDLE->LO on accept; LO->HI after ALU_LATENCY cycles; HI->RESP after ALU_LATENCY cycles; RESP->IDLE unconditionally.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 req_op, req_a and req_b SHALL be captured only at accept; later input changes SHALL have no effect on the operation in flight.
REQ-018 LO pass: alu_operand_A=a[7:0]; alu_operand_B=b[7:0] (0x01 for INC16/DEC16); alu_opcode=ADD for ADD16/INC16, SUB for SUB16/DEC16.
REQ-019 HI pass: alu_operand_A=a[15:8]; alu_operand_B=b[15:8] (0x00 for INC16/DEC16); alu_opcode=ADC for ADD16/INC16, SBC for SUB16/DEC16; carry-in is the ALU's own C from the LO pass.
REQ-020 A 4-bit down-counter SHALL time each pass; alu_result/alu_flags SHALL be sampled on the last cycle of the pass (counter==1).
REQ-021 ALU outputs SHALL hold stable for the full pass; in IDLE and RESP they SHALL be 0x00/0x00/ADD.
REQ-022 rsp_result = {HI result, LO result}, registered, valid while rsp_valid=1.
REQ-023 ADD16/SUB16: rsp_flags Z = (rsp_result==0x0000), N = 0 for ADD16 and 1 for SUB16, H and C = HI-pass H and C; rsp_flags_we=1.
REQ-024 INC16/DEC16: rsp_flags=0, rsp_flags_we=0 (flags untouched).
REQ-025 Latency: request accepted at edge 0 -> rsp_valid high exactly during cycle 2*ALU_LATENCY+1 (cycle 9 at default); req_ready returns high in the following cycle.
REQ-026 16-bit arithmetic SHALL wrap modulo 2^16; no other error indication.
REQ-027 req_valid held high while busy SHALL be ignored; a request held through RESP SHALL be accepted in the first IDLE cycle.

Reset
REQ-028 While rst=1: state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_result=0x0000, rsp_flags=0, rsp_flags_we=0, ALU outputs 0x00/0x00/ADD.
REQ-029 rst asserted mid-operation SHALL abort immediately with no response; no partial result SHALL ever be emitted.

Verification (behavioural 8-bit ALU model, ALU_LATENCY=4)
REQ-030 ADD16 0x0FFF+0x0001 -> rsp_valid at cycle 9, rsp_result=0x1000, flags Z0 N0 H1 C0, flags_we=1.
REQ-031 ADD16 0xFFFF+0x0001 -> 0x0000, Z1 N0 H1 C1.
REQ-032 SUB16 0x1000-0x0001 -> 0x0FFF, Z0 N1 H1 C0; LO pass opcode SUB, HI pass opcode SBC.
REQ-033 INC16 0xFFFF -> 0x0000, rsp_flags_we=0; DEC16 0x0000 -> 0xFFFF, rsp_flags_we=0.
REQ-034 rst pulsed during HI pass -> outputs at reset values asynchronously, rsp_valid never asserts; next ADD16 0x0001+0x0001 -> 0x0002.
REQ-035 req_valid held high with req_a changing every cycle -> exactly one response per accept, each using the operands present at its accept edge; responses 10 cycles apart.
